// File: rtl/step_ctrl_pkg.sv
// Shared state encoding for the step controller and its debouncer.
package step_ctrl_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stable-count debouncer and registered rise strobe.
module button_debouncer
   import step_ctrl_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise
);

   logic [1:0]  sync_q, sync_d;
   logic [15:0] db_cnt_q, db_cnt_d;
   logic        level_q, level_d;
   logic        prev_q, prev_d;
   logic        rise_q, rise_d;
   logic        btn_s;

   assign btn_s = sync_q[1];

   always_comb begin
      sync_d   = {sync_q[0], raw};
      db_cnt_d = '0;
      level_d  = level_q;
      if (btn_s != level_q) begin
         if (db_cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
            level_d = btn_s;
         end else begin
            db_cnt_d = db_cnt_q + 16'd1;
         end
      end
      prev_d = level_q;
      rise_d = level_q & ~prev_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q   <= '0;
         db_cnt_q <= '0;
         level_q  <= 1'b0;
         prev_q   <= 1'b0;
         rise_q   <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         db_cnt_q <= db_cnt_d;
         level_q  <= level_d;
         prev_q   <= prev_d;
         rise_q   <= rise_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;

endmodule

// File: rtl/step_controller.sv
// Step strobe generator: manual single-step, divided free-run, and an
// optional PC breakpoint halt enabled by STEP_CTRL_BREAKPOINT_EN.
module step_controller
   import step_ctrl_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [23:0] RUN_DIV         = 24'd5000000,
   parameter int unsigned STEP_CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  btn_step,
   input  logic                  run_mode,
   input  logic [31:0]           pc_in,
   input  logic [31:0]           bp_addr,
   input  logic                  bp_valid,
   output logic                  step_pulse,
   output logic                  running,
   output logic                  halted,
   output logic [STEP_CNT_W-1:0] step_count
);

   logic                  press;
   logic                  unused_level;
   logic [1:0]            run_sync_q, run_sync_d;
   logic                  run_s;
   state_t                state_q, state_d;
   logic [23:0]           div_cnt_q, div_cnt_d;
   logic                  div_wrap;
   logic                  bp_hit;
   logic                  step_pulse_q, step_pulse_d;
   logic                  running_q, running_d;
   logic                  halted_q, halted_d;
   logic [STEP_CNT_W-1:0] step_count_q, step_count_d;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_step),
      .level (unused_level),
      .rise  (press)
   );

   assign run_s    = run_sync_q[1];
   assign div_wrap = (div_cnt_q == RUN_DIV - 24'd1);

`ifdef STEP_CTRL_BREAKPOINT_EN
   assign bp_hit = bp_valid && (pc_in == bp_addr);
`else
   logic unused_bp;
   assign unused_bp = ^{bp_valid, pc_in, bp_addr};
   assign bp_hit    = 1'b0;
`endif

   // A run_s change always wins over a press, a breakpoint or a wrap.
   always_comb begin
      run_sync_d   = {run_sync_q[0], run_mode};
      state_d      = state_q;
      div_cnt_d    = '0;
      step_pulse_d = 1'b0;
      step_count_d = step_pulse_q ? step_count_q + STEP_CNT_W'(1)
                                  : step_count_q;
      unique case (state_q)
         ST_IDLE: begin
            if (run_s) state_d = ST_RUN;
            else       step_pulse_d = press;
         end
         ST_RUN: begin
            if (!run_s) begin
               state_d = ST_IDLE;
            end else if (bp_hit) begin
               state_d = ST_HALT;
            end else begin
               div_cnt_d    = div_wrap ? '0 : div_cnt_q + 24'd1;
               step_pulse_d = div_wrap;
            end
         end
         ST_HALT: begin
            if (!run_s) state_d = ST_IDLE;
            else        step_pulse_d = press;
         end
         default: state_d = ST_IDLE;
      endcase
      running_d = (state_d == ST_RUN);
      halted_d  = (state_d == ST_HALT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         run_sync_q   <= '0;
         state_q      <= ST_IDLE;
         div_cnt_q    <= '0;
         step_pulse_q <= 1'b0;
         running_q    <= 1'b0;
         halted_q     <= 1'b0;
         step_count_q <= '0;
      end else begin
         run_sync_q   <= run_sync_d;
         state_q      <= state_d;
         div_cnt_q    <= div_cnt_d;
         step_pulse_q <= step_pulse_d;
         running_q    <= running_d;
         halted_q     <= halted_d;
         step_count_q <= step_count_d;
      end
   end

   assign step_pulse = step_pulse_q;
   assign running    = running_q;
   assign halted     = halted_q;
   assign step_count = step_count_q;

endmodule

// File: tb/tb_step_controller.sv
// Bench for step_controller: vector table, directed corner sequences and
// a randomized run checked against a behavioural model every cycle.
module tb_step_controller;

   localparam int DEB = 4;
   localparam int DIV = 8;
   localparam int CW  = 4;
`ifdef STEP_CTRL_BREAKPOINT_EN
   localparam bit BP_EN = 1'b1;
`else
   localparam bit BP_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          btn_step;
   logic          run_mode;
   logic          bp_valid;
   logic [31:0]   pc_in;
   logic [31:0]   bp_addr;
   logic          step_pulse;
   logic          running;
   logic          halted;
   logic [CW-1:0] step_count;

   int n_chk  = 0;
   int n_pass = 0;

   step_controller #(
      .DEBOUNCE_CYCLES(16'(DEB)),
      .RUN_DIV        (24'(DIV)),
      .STEP_CNT_W     (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_step   (btn_step),
      .run_mode   (run_mode),
      .pc_in      (pc_in),
      .bp_addr    (bp_addr),
      .bp_valid   (bp_valid),
      .step_pulse (step_pulse),
      .running    (running),
      .halted     (halted),
      .step_count (step_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act,
                        input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      btn_step = 1'b0;
      run_mode = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   // Core PC: advances by one word on every accepted step strobe.
   always @(posedge clk) begin
      if (reset) pc_in <= '0;
      else if (step_pulse) pc_in <= pc_in + 32'd4;
   end

   // Behavioural reference: synchronized samples are the raw inputs two
   // edges late; a level is accepted after DEB agreeing samples; presses
   // reach the step logic two edges after acceptance; free-run pulses on
   // every DIV-th cycle since run entry.
   bit raw_q[$];
   bit runr_q[$];
   bit s_hist[$];
   bit m_lvl, m_p1, m_p2, m_pulse, m_run, m_halt;
   int m_phase;
   int m_cnt;
   bit chk_en = 1'b0;

   always @(posedge clk) begin : model
      bit s_btn, s_run, press, all_diff;
      if (reset) begin
         raw_q.delete();
         runr_q.delete();
         s_hist.delete();
         m_lvl = 0; m_p1 = 0; m_p2 = 0;
         m_pulse = 0; m_run = 0; m_halt = 0;
         m_phase = 0; m_cnt = 0;
         chk_en = 1'b1;
      end else begin
         s_btn = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : 1'b0;
         s_run = (runr_q.size() >= 2) ? runr_q[runr_q.size()-2] : 1'b0;
         raw_q.push_back(btn_step);
         runr_q.push_back(run_mode);
         if (raw_q.size() > 4) void'(raw_q.pop_front());
         if (runr_q.size() > 4) void'(runr_q.pop_front());
         press = m_p2;
         m_p2  = m_p1;
         s_hist.push_back(s_btn);
         if (s_hist.size() > DEB) void'(s_hist.pop_front());
         all_diff = (s_hist.size() == DEB);
         foreach (s_hist[i]) if (s_hist[i] == m_lvl) all_diff = 0;
         m_p1 = all_diff && !m_lvl;
         if (all_diff) m_lvl = !m_lvl;
         m_cnt   = (m_cnt + int'(m_pulse)) % (1 << CW);
         m_pulse = 0;
         if (m_run) begin
            if (!s_run) begin
               m_run = 0;
            end else if (BP_EN && bp_valid && pc_in == bp_addr) begin
               m_run  = 0;
               m_halt = 1;
            end else begin
               m_phase++;
               m_pulse = (m_phase % DIV == 0);
            end
         end else if (m_halt) begin
            if (!s_run) m_halt = 0;
            else        m_pulse = press;
         end else begin
            if (s_run) begin
               m_run   = 1;
               m_phase = 0;
            end else begin
               m_pulse = press;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model step_pulse", step_pulse, m_pulse);
         check("model running", running, m_run);
         check("model halted", halted, m_halt);
         check("model step_count", step_count, m_cnt);
      end
   end

   typedef struct {
      bit rst;
      bit btn;
      bit run;
      int len;
      int e_first;
      int e_pulses;
      bit e_run;
      bit e_halt;
      int e_cnt;
   } vec_t;

   vec_t vt[9];

   initial begin
      int   pulses;
      int   first;
      bit   pat[4];
      logic [31:0] pc_halt;

      vt[0] = '{1'b1, 1'b0, 1'b0,  2, -1, 0, 1'b0, 1'b0, 0};
      vt[1] = '{1'b0, 1'b1, 1'b0, 20,  7, 1, 1'b0, 1'b0, 1};
      vt[2] = '{1'b0, 1'b0, 1'b0, 10, -1, 0, 1'b0, 1'b0, 1};
      vt[3] = '{1'b0, 1'b1, 1'b0, 10,  7, 1, 1'b0, 1'b0, 2};
      vt[4] = '{1'b0, 1'b0, 1'b0, 10, -1, 0, 1'b0, 1'b0, 2};
      vt[5] = '{1'b0, 1'b0, 1'b1, 40, 10, 4, 1'b1, 1'b0, 6};
      vt[6] = '{1'b0, 1'b1, 1'b1, 20,  2, 3, 1'b1, 1'b0, 9};
      vt[7] = '{1'b0, 1'b1, 1'b0, 20, -1, 0, 1'b0, 1'b0, 9};
      vt[8] = '{1'b0, 1'b0, 1'b0, 10, -1, 0, 1'b0, 1'b0, 9};

      reset    = 1'b1;
      btn_step = 1'b0;
      run_mode = 1'b0;
      bp_valid = 1'b0;
      bp_addr  = '0;

      for (int r = 0; r < 9; r++) begin
         reset    = vt[r].rst;
         btn_step = vt[r].btn;
         run_mode = vt[r].run;
         pulses   = 0;
         first    = -1;
         for (int i = 0; i < vt[r].len; i++) begin
            cyc();
            if (step_pulse) begin
               pulses++;
               if (first < 0) first = i;
            end
         end
         check($sformatf("vec%0d first pulse", r), first, vt[r].e_first);
         check($sformatf("vec%0d pulses", r), pulses, vt[r].e_pulses);
         check($sformatf("vec%0d running", r), running, vt[r].e_run);
         check($sformatf("vec%0d halted", r), halted, vt[r].e_halt);
         check($sformatf("vec%0d count", r), step_count, vt[r].e_cnt);
      end

      // Bouncy press then bouncy release.
      do_reset();
      pat = '{1'b1, 1'b0, 1'b1, 1'b0};
      pulses = 0;
      foreach (pat[i]) begin
         btn_step = pat[i];
         cyc();
         pulses += int'(step_pulse);
      end
      btn_step = 1'b1;
      first    = -1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (step_pulse) begin
            pulses++;
            if (first < 0) first = i;
         end
      end
      check("bounce press latency", first, 7);
      check("bounce press pulses", pulses, 1);
      pulses = 0;
      foreach (pat[i]) begin
         btn_step = ~pat[i];
         cyc();
         pulses += int'(step_pulse);
      end
      btn_step = 1'b0;
      for (int i = 0; i < 15; i++) begin
         cyc();
         pulses += int'(step_pulse);
      end
      check("bounce release pulses", pulses, 0);
      check("bounce count", step_count, 1);

      // Breakpoint halt during free-run, then manual step while halted.
      do_reset();
      bp_valid = 1'b1;
      bp_addr  = 32'h0000_000C;
      run_mode = 1'b1;
      pulses   = 0;
      for (int i = 0; i < 60; i++) begin
         cyc();
         if (halted) break;
         pulses += int'(step_pulse);
      end
      pc_halt = pc_in;
`ifdef STEP_CTRL_BREAKPOINT_EN
      check("bp halted", halted, 1);
      check("bp running", running, 0);
      check("bp pulse in halt cycle", step_pulse, 0);
      check("bp pulses before halt", pulses, 3);
      check("bp pc at halt", pc_halt, 32'hC);
      btn_step = 1'b1;
      pulses   = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         pulses += int'(step_pulse);
      end
      check("bp manual pulses", pulses, 1);
      check("bp still halted", halted, 1);
      check("bp pc after step", pc_in, 32'h10);
      btn_step = 1'b0;
      run_mode = 1'b0;
      repeat (10) cyc();
      check("bp leave halt", halted, 0);
`else
      check("no-bp halted", halted, 0);
      check("no-bp running", running, 1);
      check("no-bp pulses", pulses, 7);
`endif
      bp_valid = 1'b0;
      run_mode = 1'b0;

      // Counter wrap over 17 presses.
      do_reset();
      for (int k = 0; k < 17; k++) begin
         btn_step = 1'b1;
         repeat (10) cyc();
         check($sformatf("wrap press %0d", k), step_count, (k + 1) % 16);
         btn_step = 1'b0;
         repeat (10) cyc();
      end

      // Reset during run with div_cnt at 5 and a debounce in progress.
      do_reset();
      run_mode = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (running) break;
      end
      check("midop running seen", running, 1);
      cyc();
      cyc();
      btn_step = 1'b1;
      cyc();
      cyc();
      cyc();
      reset    = 1'b1;
      run_mode = 1'b0;
      btn_step = 1'b0;
      cyc();
      check("midop pulse", step_pulse, 0);
      check("midop running", running, 0);
      check("midop halted", halted, 0);
      check("midop count", step_count, 0);
      reset  = 1'b0;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         cyc();
         pulses += int'(step_pulse);
      end
      check("midop quiet after reset", pulses, 0);

      // Button held through reset counts as a fresh press.
      btn_step = 1'b1;
      repeat (12) cyc();
      reset = 1'b1;
      cyc();
      cyc();
      reset  = 1'b0;
      pulses = 0;
      first  = -1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (step_pulse) begin
            pulses++;
            if (first < 0) first = i;
         end
      end
      check("held-through-reset latency", first, 7);
      check("held-through-reset pulses", pulses, 1);
      btn_step = 1'b0;
      repeat (10) cyc();

      // Randomized traffic, checked by the model every cycle.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 5) == 0) btn_step = ~btn_step;
         if ($urandom_range(0, 79) == 0) run_mode = ~run_mode;
         if ($urandom_range(0, 39) == 0) begin
            bp_valid = 1'($urandom_range(0, 1));
            bp_addr  = pc_in + 32'(4 * $urandom_range(0, 3));
         end
         reset = ($urandom_range(0, 599) == 0);
         cyc();
      end
      reset = 1'b0;
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
